// File: rtl/ddr_pkg.sv
// ---------------------------------------------------------------------------
// ddr_pkg
// Shared definitions for the note judging block: slot geometry, lane bit
// indices, special lane masks, slot state encoding, score weights and the
// retire arbiter helper.
// No ports (package).
// ---------------------------------------------------------------------------
package ddr_pkg;

   localparam int SLOTS   = 8;
   localparam int Y_WIDTH = 10;

   // Lane bit positions inside a 4-bit lane mask / key vector.
   localparam int LANE_L = 0;
   localparam int LANE_D = 1;
   localparam int LANE_U = 2;
   localparam int LANE_R = 3;

   // A spawn carrying every lane marks the end of the song; an empty mask
   // is a pure refill request that retires immediately.
   localparam logic [3:0] LANE_END  = 4'hF;
   localparam logic [3:0] LANE_NONE = 4'h0;

   localparam logic [15:0] SCORE_PERFECT = 16'd10;
   localparam logic [15:0] SCORE_GOOD    = 16'd5;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_FALLING  = 2'd1,
      ST_RESOLVED = 2'd2
   } slot_state_e;

   // Isolate the lowest set bit: lowest-index slot wins the retire port.
   function automatic logic [SLOTS-1:0] lowest_one(input logic [SLOTS-1:0] req);
      return req & (~req + {{(SLOTS-1){1'b0}}, 1'b1});
   endfunction

endpackage

// File: rtl/note_slot.sv
// ---------------------------------------------------------------------------
// note_slot
// One falling-note slot: IDLE -> FALLING -> RESOLVED -> IDLE. Holds the lane
// mask, the still-pending key mask and the vertical position, and reports a
// hit or miss in the cycle the slot resolves.
// Ports:
//   clk, rst        clock, async active-low reset
//   spawn_edge      rising edge of this slot's spawn request
//   lane            lane mask presented with the spawn
//   animate         frame tick, advances y while falling
//   key_edge        rising edges of the four player keys
//   retire          this slot holds the retire port this cycle
//   active          slot is falling
//   y               current vertical position
//   resolve_next    slot will be RESOLVED after the coming edge
//   hit, perfect    slot resolves as a hit this cycle (perfect = inner window)
//   miss            slot resolves as a miss this cycle
//   song_end        end-of-song spawn seen this cycle
// ---------------------------------------------------------------------------
module note_slot
   import ddr_pkg::*;
#(
   parameter int FALL_STEP  = 2,
   parameter int HIT_Y      = 400,
   parameter int HIT_WINDOW = 16,
   parameter int MISS_Y     = 440
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               spawn_edge,
   input  logic [3:0]         lane,
   input  logic               animate,
   input  logic [3:0]         key_edge,
   input  logic               retire,
   output logic               active,
   output logic [Y_WIDTH-1:0] y,
   output logic               resolve_next,
   output logic               hit,
   output logic               perfect,
   output logic               miss,
   output logic               song_end
);

   localparam logic [Y_WIDTH:0]   HIT_Y_V  = (Y_WIDTH+1)'(HIT_Y);
   localparam logic [Y_WIDTH:0]   WINDOW_V = (Y_WIDTH+1)'(HIT_WINDOW);
   localparam logic [Y_WIDTH:0]   HALF_V   = (Y_WIDTH+1)'(HIT_WINDOW / 2);
   localparam logic [Y_WIDTH-1:0] MISS_V   = Y_WIDTH'(MISS_Y);
   localparam logic [Y_WIDTH-1:0] STEP_V   = Y_WIDTH'(FALL_STEP);

   slot_state_e        state_r, state_s;
   logic [3:0]         lane_r, lane_s;
   logic [3:0]         pending_r, pending_s;
   logic [Y_WIDTH-1:0] y_r, y_s;

   logic signed [Y_WIDTH:0] diff_s;
   logic [Y_WIDTH:0]        dist_s;
   logic [Y_WIDTH:0]        y_sum_s;
   logic [Y_WIDTH-1:0]      y_step_s;
   logic                    in_window_s;
   logic                    in_perfect_s;

   // Distance to the hit line is taken one bit wider and signed so notes
   // above and below the line compare correctly.
   assign diff_s       = $signed({1'b0, y_r}) - $signed(HIT_Y_V);
   assign dist_s       = diff_s[Y_WIDTH] ? $unsigned(-diff_s) : $unsigned(diff_s);
   assign in_window_s  = (dist_s <= WINDOW_V);
   assign in_perfect_s = (dist_s <= HALF_V);

   // Fall step saturates at the bottom of the coordinate range.
   assign y_sum_s  = {1'b0, y_r} + {1'b0, STEP_V};
   assign y_step_s = y_sum_s[Y_WIDTH] ? {Y_WIDTH{1'b1}} : y_sum_s[Y_WIDTH-1:0];

   // Next-state, pending-mask and position update for the slot.
   always_comb begin
      state_s   = state_r;
      lane_s    = lane_r;
      pending_s = pending_r;
      y_s       = y_r;
      hit       = 1'b0;
      perfect   = 1'b0;
      miss      = 1'b0;
      song_end  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (spawn_edge) begin
               if (lane == LANE_END) begin
                  song_end = 1'b1;
               end else begin
                  lane_s    = lane;
                  pending_s = lane;
                  y_s       = {Y_WIDTH{1'b0}};
                  if (lane == LANE_NONE) begin
                     state_s = ST_RESOLVED;
                  end else begin
                     state_s = ST_FALLING;
                  end
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_FALLING: begin
            // Judging uses the registered y, so an animate tick in the same
            // cycle never shifts a note into or out of the window.
            if (pending_r == 4'h0) begin
               hit     = 1'b1;
               perfect = in_perfect_s;
               state_s = ST_RESOLVED;
            end else if (y_r >= MISS_V) begin
               miss    = 1'b1;
               state_s = ST_RESOLVED;
            end else begin
               if (in_window_s) begin
                  pending_s = pending_r & ~(key_edge & lane_r);
               end else begin
                  pending_s = pending_r;
               end
               if (animate) begin
                  y_s = y_step_s;
               end else begin
                  y_s = y_r;
               end
            end
         end
         ST_RESOLVED: begin
            if (retire) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_RESOLVED;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Slot state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r   <= ST_IDLE;
         lane_r    <= 4'h0;
         pending_r <= 4'h0;
         y_r       <= {Y_WIDTH{1'b0}};
      end else begin
         state_r   <= state_s;
         lane_r    <= lane_s;
         pending_r <= pending_s;
         y_r       <= y_s;
      end
   end

   assign active       = (state_r == ST_FALLING);
   assign y            = y_r;
   assign resolve_next = (state_s == ST_RESOLVED);

endmodule

// File: rtl/note_judge.sv
// ---------------------------------------------------------------------------
// note_judge
// Consumer end of the note spawn/despawn interface. Tracks SLOTS falling
// notes, judges key presses against the hit line, accumulates score/combo
// and retires resolved slots one at a time back to the spawner.
// Ports:
//   clk, rst     clock, async active-low reset
//   animate      frame tick
//   note_spawn   per-slot spawn request (rising edge starts the slot)
//   locations    4-bit lane mask per slot, slot i at [4i+3:4i]
//   keys         player buttons, level, L/D/U/R = bits 0..3
//   noteAction   one-hot retire pulse to the spawner
//   slot_active  slot i falling
//   slot_y       packed y per slot
//   hit_pulse    a hit was judged
//   miss_pulse   a miss was judged
//   score        saturating score
//   combo        consecutive hits, saturating
//   song_end     sticky end-of-song flag
// ---------------------------------------------------------------------------
module note_judge
   import ddr_pkg::*;
#(
   parameter int FALL_STEP  = 2,
   parameter int HIT_Y      = 400,
   parameter int HIT_WINDOW = 16,
   parameter int MISS_Y     = 440
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       animate,
   input  logic [SLOTS-1:0]           note_spawn,
   input  logic [4*SLOTS-1:0]         locations,
   input  logic [3:0]                 keys,
   output logic [SLOTS-1:0]           noteAction,
   output logic [SLOTS-1:0]           slot_active,
   output logic [SLOTS*Y_WIDTH-1:0]   slot_y,
   output logic                       hit_pulse,
   output logic                       miss_pulse,
   output logic [15:0]                score,
   output logic [7:0]                 combo,
   output logic                       song_end
);

   logic [3:0]       keys_q_r;
   logic [SLOTS-1:0] spawn_q_r;
   logic [3:0]       key_edge_s;
   logic [SLOTS-1:0] spawn_edge_s;

   logic [SLOTS-1:0] resolve_next_s;
   logic [SLOTS-1:0] hit_s;
   logic [SLOTS-1:0] perfect_s;
   logic [SLOTS-1:0] miss_s;
   logic [SLOTS-1:0] song_end_s;

   logic [SLOTS-1:0] note_action_r;
   logic             hit_pulse_r;
   logic             miss_pulse_r;
   logic [15:0]      score_r, score_s;
   logic [7:0]       combo_r, combo_s;
   logic             song_end_r;

   logic [3:0]       hit_cnt_s;
   logic [16:0]      add_s;
   logic [16:0]      score_sum_s;
   logic [8:0]       combo_sum_s;

   assign key_edge_s   = keys & ~keys_q_r;
   assign spawn_edge_s = note_spawn & ~spawn_q_r;

   for (genvar i = 0; i < SLOTS; i++) begin : g_slot
      note_slot #(
         .FALL_STEP  (FALL_STEP),
         .HIT_Y      (HIT_Y),
         .HIT_WINDOW (HIT_WINDOW),
         .MISS_Y     (MISS_Y)
      ) u_slot (
         .clk          (clk),
         .rst          (rst),
         .spawn_edge   (spawn_edge_s[i]),
         .lane         (locations[4*i +: 4]),
         .animate      (animate),
         .key_edge     (key_edge_s),
         .retire       (note_action_r[i]),
         .active       (slot_active[i]),
         .y            (slot_y[i*Y_WIDTH +: Y_WIDTH]),
         .resolve_next (resolve_next_s[i]),
         .hit          (hit_s[i]),
         .perfect      (perfect_s[i]),
         .miss         (miss_s[i]),
         .song_end     (song_end_s[i])
      );
   end

   // Sum every hit resolving this cycle; any miss breaks the combo after
   // those hits are counted.
   always_comb begin
      hit_cnt_s = 4'd0;
      add_s     = 17'd0;
      for (int i = 0; i < SLOTS; i++) begin
         if (hit_s[i]) begin
            hit_cnt_s = hit_cnt_s + 4'd1;
            if (perfect_s[i]) begin
               add_s = add_s + {1'b0, SCORE_PERFECT};
            end else begin
               add_s = add_s + {1'b0, SCORE_GOOD};
            end
         end else begin
            hit_cnt_s = hit_cnt_s;
         end
      end
      score_sum_s = {1'b0, score_r} + add_s;
      combo_sum_s = {1'b0, combo_r} + {5'd0, hit_cnt_s};
      if (score_sum_s[16]) begin
         score_s = 16'hFFFF;
      end else begin
         score_s = score_sum_s[15:0];
      end
      if (|miss_s) begin
         combo_s = 8'd0;
      end else if (combo_sum_s[8]) begin
         combo_s = 8'hFF;
      end else begin
         combo_s = combo_sum_s[7:0];
      end
   end

   // Edge detect, retire arbitration and judged-result registers. The
   // arbiter looks at next-state so the grant is visible in the first cycle
   // a slot is RESOLVED; the granted slot returns to IDLE on the edge that
   // ends the pulse and therefore never wins twice.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         keys_q_r      <= 4'h0;
         spawn_q_r     <= {SLOTS{1'b0}};
         note_action_r <= {SLOTS{1'b0}};
         hit_pulse_r   <= 1'b0;
         miss_pulse_r  <= 1'b0;
         score_r       <= 16'd0;
         combo_r       <= 8'd0;
         song_end_r    <= 1'b0;
      end else begin
         keys_q_r      <= keys;
         spawn_q_r     <= note_spawn;
         note_action_r <= lowest_one(resolve_next_s);
         hit_pulse_r   <= |hit_s;
         miss_pulse_r  <= |miss_s;
         score_r       <= score_s;
         combo_r       <= combo_s;
         song_end_r    <= song_end_r | (|song_end_s);
      end
   end

   assign noteAction = note_action_r;
   assign hit_pulse  = hit_pulse_r;
   assign miss_pulse = miss_pulse_r;
   assign score      = score_r;
   assign combo      = combo_r;
   assign song_end   = song_end_r;

endmodule
